// File: rtl/axilite_pkg.sv
// rtl/axilite_pkg.sv - AXI-Lite response codes, adder slave register offsets and sequencer states
package axilite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int OFS_A   = 0;
   localparam int OFS_B   = 4;
   localparam int OFS_SUM = 8;
   localparam int OFS_OVF = 12;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_A,
      ST_WR_B,
      ST_RD_SUM,
      ST_RD_OVF,
      ST_RESP
   } state_t;

   typedef enum logic [2:0] {
      X_IDLE,
      X_WR,
      X_B,
      X_AR,
      X_R
   } xact_state_t;

   function automatic logic resp_bad(input logic [1:0] resp);
      return resp != RESP_OKAY;
   endfunction

endpackage

// File: rtl/axilite_m_xact.sv
// rtl/axilite_m_xact.sv - single AXI-Lite read or write transaction engine
// done, rdata and resp are valid only in the cycle of the final B or R handshake.
module axilite_m_xact
   import axilite_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  rnw,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic [1:0]            resp,
   output logic [ADDR_WIDTH-1:0] axi_awaddr,
   output logic                  axi_awvalid,
   input  logic                  axi_awready,
   output logic [DATA_WIDTH-1:0] axi_wdata,
   output logic                  axi_wvalid,
   input  logic                  axi_wready,
   input  logic [1:0]            axi_bresp,
   input  logic                  axi_bvalid,
   output logic                  axi_bready,
   output logic [ADDR_WIDTH-1:0] axi_araddr,
   output logic                  axi_arvalid,
   input  logic                  axi_arready,
   input  logic [DATA_WIDTH-1:0] axi_rdata,
   input  logic [1:0]            axi_rresp,
   input  logic                  axi_rvalid,
   output logic                  axi_rready
);

   xact_state_t           state, state_n;
   logic                  aw_v, aw_v_n, w_v, w_v_n, b_r, b_r_n;
   logic                  ar_v, ar_v_n, r_r, r_r_n;
   logic [ADDR_WIDTH-1:0] aw_a, aw_a_n, ar_a, ar_a_n;
   logic [DATA_WIDTH-1:0] w_d, w_d_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= X_IDLE;
         aw_v  <= 1'b0;
         w_v   <= 1'b0;
         b_r   <= 1'b0;
         ar_v  <= 1'b0;
         r_r   <= 1'b0;
         aw_a  <= '0;
         ar_a  <= '0;
         w_d   <= '0;
      end else begin
         state <= state_n;
         aw_v  <= aw_v_n;
         w_v   <= w_v_n;
         b_r   <= b_r_n;
         ar_v  <= ar_v_n;
         r_r   <= r_r_n;
         aw_a  <= aw_a_n;
         ar_a  <= ar_a_n;
         w_d   <= w_d_n;
      end
   end

   // Address and data registers only reload on start, so they stay put through the B handshake.
   always_comb begin
      state_n = state;
      aw_v_n  = aw_v;
      w_v_n   = w_v;
      b_r_n   = b_r;
      ar_v_n  = ar_v;
      r_r_n   = r_r;
      aw_a_n  = aw_a;
      ar_a_n  = ar_a;
      w_d_n   = w_d;
      done    = 1'b0;
      case (state)
         X_IDLE: begin
            if (start) begin
               if (rnw) begin
                  ar_v_n  = 1'b1;
                  ar_a_n  = addr;
                  state_n = X_AR;
               end else begin
                  aw_v_n  = 1'b1;
                  w_v_n   = 1'b1;
                  aw_a_n  = addr;
                  w_d_n   = wdata;
                  state_n = X_WR;
               end
            end
         end
         X_WR: begin
            aw_v_n = aw_v & ~axi_awready;
            w_v_n  = w_v & ~axi_wready;
            if (!aw_v_n && !w_v_n) begin
               b_r_n   = 1'b1;
               state_n = X_B;
            end
         end
         X_B: begin
            if (axi_bvalid) begin
               b_r_n   = 1'b0;
               done    = 1'b1;
               state_n = X_IDLE;
            end
         end
         X_AR: begin
            if (axi_arready) begin
               ar_v_n  = 1'b0;
               r_r_n   = 1'b1;
               state_n = X_R;
            end
         end
         X_R: begin
            if (axi_rvalid) begin
               r_r_n   = 1'b0;
               done    = 1'b1;
               state_n = X_IDLE;
            end
         end
         default: state_n = X_IDLE;
      endcase
   end

   assign rdata       = axi_rdata;
   assign resp        = (state == X_B) ? axi_bresp : axi_rresp;
   assign axi_awaddr  = aw_a;
   assign axi_awvalid = aw_v;
   assign axi_wdata   = w_d;
   assign axi_wvalid  = w_v;
   assign axi_bready  = b_r;
   assign axi_araddr  = ar_a;
   assign axi_arvalid = ar_v;
   assign axi_rready  = r_r;

endmodule

// File: rtl/axilite_adder_master.sv
// rtl/axilite_adder_master.sv - AXI-Lite master writing A/B to the adder slave and reading back SUM/OVF
module axilite_adder_master
   import axilite_pkg::*;
#(
   parameter int                            C_M_AXI_ADDR_WIDTH      = 32,
   parameter int                            C_M_AXI_DATA_WIDTH      = 32,
   parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_M_AXI_TARGET_BASEADDR = '0
) (
   input  logic                          M_AXI_ACLK,
   input  logic                          M_AXI_ARESET,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [C_M_AXI_DATA_WIDTH-1:0] cmd_a,
   input  logic [C_M_AXI_DATA_WIDTH-1:0] cmd_b,
   output logic                          res_valid,
   input  logic                          res_ready,
   output logic [C_M_AXI_DATA_WIDTH-1:0] res_sum,
   output logic                          res_ovf,
   output logic                          res_err,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
   output logic                          M_AXI_AWVALID,
   input  logic                          M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
   output logic                          M_AXI_WVALID,
   input  logic                          M_AXI_WREADY,
   input  logic [1:0]                    M_AXI_BRESP,
   input  logic                          M_AXI_BVALID,
   output logic                          M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
   output logic                          M_AXI_ARVALID,
   input  logic                          M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
   input  logic [1:0]                    M_AXI_RRESP,
   input  logic                          M_AXI_RVALID,
   output logic                          M_AXI_RREADY
);

   localparam int AW = C_M_AXI_ADDR_WIDTH;
   localparam int DW = C_M_AXI_DATA_WIDTH;

   // Register addresses wrap modulo 2^AW when the window sits at the top of the map.
   localparam logic [AW-1:0] ADDR_A   = C_M_AXI_TARGET_BASEADDR + AW'(OFS_A);
   localparam logic [AW-1:0] ADDR_B   = C_M_AXI_TARGET_BASEADDR + AW'(OFS_B);
   localparam logic [AW-1:0] ADDR_SUM = C_M_AXI_TARGET_BASEADDR + AW'(OFS_SUM);
   localparam logic [AW-1:0] ADDR_OVF = C_M_AXI_TARGET_BASEADDR + AW'(OFS_OVF);

   state_t          state, state_n;
   logic [DW-1:0]   a_q, a_n, b_q, b_n, sum_q, sum_n;
   logic            err_q, err_n, ovf_q, ovf_n, rerr_q, rerr_n, rv_q, rv_n;

   logic            x_start, x_rnw, x_done, x_bad;
   logic [AW-1:0]   x_addr;
   logic [DW-1:0]   x_wdata, x_rdata;
   logic [1:0]      x_resp;

   assign x_bad = resp_bad(x_resp);

   always_ff @(posedge M_AXI_ACLK) begin
      if (M_AXI_ARESET) begin
         state  <= ST_IDLE;
         a_q    <= '0;
         b_q    <= '0;
         sum_q  <= '0;
         err_q  <= 1'b0;
         ovf_q  <= 1'b0;
         rerr_q <= 1'b0;
         rv_q   <= 1'b0;
      end else begin
         state  <= state_n;
         a_q    <= a_n;
         b_q    <= b_n;
         sum_q  <= sum_n;
         err_q  <= err_n;
         ovf_q  <= ovf_n;
         rerr_q <= rerr_n;
         rv_q   <= rv_n;
      end
   end

   // start is held through each phase; the engine only samples it when idle, and it
   // returns to idle on the same edge this FSM advances, so each phase launches exactly once.
   always_comb begin
      state_n = state;
      a_n     = a_q;
      b_n     = b_q;
      sum_n   = sum_q;
      err_n   = err_q;
      ovf_n   = ovf_q;
      rerr_n  = rerr_q;
      rv_n    = rv_q;
      x_start = 1'b0;
      x_rnw   = 1'b0;
      x_addr  = ADDR_A;
      x_wdata = a_q;
      case (state)
         ST_IDLE: begin
            if (cmd_valid) begin
               a_n     = cmd_a;
               b_n     = cmd_b;
               err_n   = 1'b0;
               state_n = ST_WR_A;
            end
         end
         ST_WR_A: begin
            x_start = 1'b1;
            if (x_done) begin
               err_n   = err_q | x_bad;
               state_n = ST_WR_B;
            end
         end
         ST_WR_B: begin
            x_start = 1'b1;
            x_addr  = ADDR_B;
            x_wdata = b_q;
            if (x_done) begin
               err_n   = err_q | x_bad;
               state_n = ST_RD_SUM;
            end
         end
         ST_RD_SUM: begin
            x_start = 1'b1;
            x_rnw   = 1'b1;
            x_addr  = ADDR_SUM;
            if (x_done) begin
               sum_n   = x_rdata;
               err_n   = err_q | x_bad;
               state_n = ST_RD_OVF;
            end
         end
         ST_RD_OVF: begin
            x_start = 1'b1;
            x_rnw   = 1'b1;
            x_addr  = ADDR_OVF;
            if (x_done) begin
               ovf_n   = |x_rdata;
               err_n   = err_q | x_bad;
               rerr_n  = err_q | x_bad;
               rv_n    = 1'b1;
               state_n = ST_RESP;
            end
         end
         ST_RESP: begin
            if (res_ready) begin
               rv_n    = 1'b0;
               state_n = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign cmd_ready = (state == ST_IDLE);
   assign res_valid = rv_q;
   assign res_sum   = sum_q;
   assign res_ovf   = ovf_q;
   assign res_err   = rerr_q;

   axilite_m_xact #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW)
   ) u_xact (
      .clk         (M_AXI_ACLK),
      .rst         (M_AXI_ARESET),
      .start       (x_start),
      .rnw         (x_rnw),
      .addr        (x_addr),
      .wdata       (x_wdata),
      .done        (x_done),
      .rdata       (x_rdata),
      .resp        (x_resp),
      .axi_awaddr  (M_AXI_AWADDR),
      .axi_awvalid (M_AXI_AWVALID),
      .axi_awready (M_AXI_AWREADY),
      .axi_wdata   (M_AXI_WDATA),
      .axi_wvalid  (M_AXI_WVALID),
      .axi_wready  (M_AXI_WREADY),
      .axi_bresp   (M_AXI_BRESP),
      .axi_bvalid  (M_AXI_BVALID),
      .axi_bready  (M_AXI_BREADY),
      .axi_araddr  (M_AXI_ARADDR),
      .axi_arvalid (M_AXI_ARVALID),
      .axi_arready (M_AXI_ARREADY),
      .axi_rdata   (M_AXI_RDATA),
      .axi_rresp   (M_AXI_RRESP),
      .axi_rvalid  (M_AXI_RVALID),
      .axi_rready  (M_AXI_RREADY)
   );

endmodule

// File: tb/tb_axilite_adder_master.sv
// tb/tb_axilite_adder_master.sv - directed bench for axilite_adder_master with an adder slave model
module tb_axilite_adder_master;
   import axilite_pkg::*;

   localparam logic [31:0] BASE = 32'hFFFF_FFF8;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, res_valid, res_ready, res_ovf, res_err;
   logic [31:0] cmd_a, cmd_b, res_sum;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [1:0]  bresp, rresp;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   axilite_adder_master #(
      .C_M_AXI_ADDR_WIDTH      (32),
      .C_M_AXI_DATA_WIDTH      (32),
      .C_M_AXI_TARGET_BASEADDR (BASE)
   ) dut (
      .M_AXI_ACLK    (clk),
      .M_AXI_ARESET  (rst),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_a         (cmd_a),
      .cmd_b         (cmd_b),
      .res_valid     (res_valid),
      .res_ready     (res_ready),
      .res_sum       (res_sum),
      .res_ovf       (res_ovf),
      .res_err       (res_err),
      .M_AXI_AWADDR  (awaddr),
      .M_AXI_AWVALID (awvalid),
      .M_AXI_AWREADY (awready),
      .M_AXI_WDATA   (wdata),
      .M_AXI_WVALID  (wvalid),
      .M_AXI_WREADY  (wready),
      .M_AXI_BRESP   (bresp),
      .M_AXI_BVALID  (bvalid),
      .M_AXI_BREADY  (bready),
      .M_AXI_ARADDR  (araddr),
      .M_AXI_ARVALID (arvalid),
      .M_AXI_ARREADY (arready),
      .M_AXI_RDATA   (rdata),
      .M_AXI_RRESP   (rresp),
      .M_AXI_RVALID  (rvalid),
      .M_AXI_RREADY  (rready)
   );

   // Adder slave: readies after a programmable number of waiting cycles, B one cycle after AW+W.
   int          aw_delay, w_delay, ar_delay;
   bit          slv_err;
   int          aw_cnt, w_cnt, ar_cnt;
   logic        aw_got, w_got;
   logic [31:0] s_awaddr, s_wdata;
   logic [31:0] regs [4];

   assign awready = awvalid && (aw_cnt >= aw_delay);
   assign wready  = wvalid && (w_cnt >= w_delay);
   assign arready = arvalid && (ar_cnt >= ar_delay);

   function automatic logic [1:0] slv_idx(input logic [31:0] addr);
      logic [31:0] off;
      off = addr - BASE;
      return off[3:2];
   endfunction

   function automatic logic [31:0] slv_read(input logic [31:0] addr);
      logic [31:0] s;
      s = regs[0] + regs[1];
      case (slv_idx(addr))
         2'd0:    return regs[0];
         2'd1:    return regs[1];
         2'd2:    return s;
         default: return {31'b0, (regs[0][31] == regs[1][31]) && (s[31] != regs[0][31])};
      endcase
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         aw_cnt <= 0;
         w_cnt  <= 0;
         ar_cnt <= 0;
         aw_got <= 1'b0;
         w_got  <= 1'b0;
         bvalid <= 1'b0;
         bresp  <= RESP_OKAY;
         rvalid <= 1'b0;
         rresp  <= RESP_OKAY;
         rdata  <= '0;
      end else begin
         aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
         w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
         ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
         if (awvalid && awready) begin
            aw_got   <= 1'b1;
            s_awaddr <= awaddr;
         end
         if (wvalid && wready) begin
            w_got   <= 1'b1;
            s_wdata <= wdata;
         end
         if (aw_got && w_got) begin
            bvalid <= 1'b1;
            bresp  <= slv_err ? RESP_SLVERR : RESP_OKAY;
            if (!slv_err) regs[slv_idx(s_awaddr)] <= s_wdata;
            aw_got <= 1'b0;
            w_got  <= 1'b0;
         end
         if (bvalid && bready) bvalid <= 1'b0;
         if (arvalid && arready) begin
            rvalid <= 1'b1;
            rresp  <= slv_err ? RESP_SLVERR : RESP_OKAY;
            rdata  <= slv_err ? 32'h0 : slv_read(araddr);
         end
         if (rvalid && rready) rvalid <= 1'b0;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Monitor state: address log {is_read, addr}, VALID high-cycle counts per handshake.
   logic [32:0] xlog [$];
   int          aw_len [$];
   int          w_len [$];
   bit          armed = 1'b0;
   bit          aw_done, w_done;
   logic [31:0] aw_addr_q;
   int          aw_run, w_run;
   logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
   logic [31:0] p_awaddr, p_wdata, p_araddr;

   task automatic monitor();
      forever begin
         @(posedge clk);
         if (rst) begin
            armed   = 1'b1;
            aw_done = 1'b0;
            w_done  = 1'b0;
            aw_run  = 0;
            w_run   = 0;
            {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr} = '0;
         end else if (armed) begin
            check("no_x", $isunknown({cmd_ready, res_valid, res_sum, res_ovf, res_err, awaddr, awvalid,
                                      wdata, wvalid, bready, araddr, arvalid, rready}), 1'b0);
            if (p_awv && !p_awr) check("aw_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
            if (p_wv && !p_wr)   check("w_hold", {wvalid, wdata}, {1'b1, p_wdata});
            if (p_arv && !p_arr) check("ar_hold", {arvalid, araddr}, {1'b1, p_araddr});
            if (bready)          check("bready_early", {aw_done, w_done}, 2'b11);
            if (aw_done)         check("awaddr_stable", awaddr, aw_addr_q);
            if (awvalid) begin
               if (awready) begin
                  aw_len.push_back(aw_run + 1);
                  aw_run = 0;
                  xlog.push_back({1'b0, awaddr});
                  aw_done   = 1'b1;
                  aw_addr_q = awaddr;
               end else aw_run++;
            end
            if (wvalid) begin
               if (wready) begin
                  w_len.push_back(w_run + 1);
                  w_run  = 0;
                  w_done = 1'b1;
               end else w_run++;
            end
            if (arvalid && arready) xlog.push_back({1'b1, araddr});
            if (bvalid && bready) begin
               aw_done = 1'b0;
               w_done  = 1'b0;
            end
            {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr} = {awvalid, awready, wvalid, wready, arvalid, arready};
            p_awaddr = awaddr;
            p_wdata  = wdata;
            p_araddr = araddr;
         end
      end
   endtask

   task automatic run_cmd(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_sum,
                          input logic exp_ovf, input logic exp_err, input int max_lat);
      int n;
      xlog.delete();
      aw_len.delete();
      w_len.delete();
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      cmd_valid = 1'b1;
      cmd_a     = a;
      cmd_b     = b;
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 1;
      while (!res_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("res_valid_seen", res_valid, 1'b1);
      check("latency_ok", n <= max_lat, 1'b1);
      check("res_sum", res_sum, exp_sum);
      check("res_ovf", res_ovf, exp_ovf);
      check("res_err", res_err, exp_err);
   endtask

   task automatic take_resp();
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check("res_valid_drop", res_valid, 1'b0);
      check("cmd_ready_back", cmd_ready, 1'b1);
   endtask

   task automatic check_log();
      logic [32:0] exp_log [4];
      exp_log = '{33'h0_FFFF_FFF8, 33'h0_FFFF_FFFC, 33'h1_0000_0000, 33'h1_0000_0004};
      check("log_len", xlog.size(), 4);
      for (int i = 0; i < 4 && i < xlog.size(); i++) check("log_addr", xlog[i], exp_log[i]);
   endtask

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_a     = '0;
      cmd_b     = '0;
      res_ready = 1'b0;
      aw_delay  = 0;
      w_delay   = 0;
      ar_delay  = 0;
      slv_err   = 1'b0;
      fork
         monitor();
      join_none

      repeat (3) @(negedge clk);
      check("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
      check("rst_res", {res_valid, res_err, res_ovf}, 3'b0);
      check("rst_sum", res_sum, 32'h0);
      check("rst_addr", {awaddr, araddr}, 64'h0);
      check("rst_wdata", wdata, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      check("cmd_ready_after_rst", cmd_ready, 1'b1);

      run_cmd(32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 16);
      check_log();
      take_resp();

      run_cmd(32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b1, 1'b0, 16);
      take_resp();

      run_cmd(32'h8000_0000, 32'h8000_0000, 32'h0, 1'b1, 1'b0, 16);
      take_resp();

      aw_delay = 3;
      w_delay  = 1;
      run_cmd(32'd10, 32'd20, 32'd30, 1'b0, 1'b0, 60);
      check("aw_len_n", aw_len.size(), 2);
      check("w_len_n", w_len.size(), 2);
      if (aw_len.size() == 2) check("awvalid_cycles", aw_len[0], 4);
      if (w_len.size() == 2)  check("wvalid_cycles", w_len[0], 2);
      take_resp();
      aw_delay = 0;
      w_delay  = 0;

      slv_err = 1'b1;
      run_cmd(32'd1, 32'd1, 32'h0, 1'b0, 1'b1, 16);
      check_log();
      take_resp();
      slv_err = 1'b0;

      run_cmd(32'd3,32'd4, 32'd7, 1'b0, 1'b0, 16);
      for (int i = 0; i < 10; i++) begin
         cmd_valid = i[0];
         cmd_a     = 32'd99;
         @(negedge clk);
         check("stall_valid", res_valid, 1'b1);
         check("stall_sum", res_sum, 32'd7);
         check("stall_cmd_ready", cmd_ready, 1'b0);
      end
      cmd_valid = 1'b0;
      check("stall_no_xact", xlog.size(), 4);
      take_resp();
      repeat (2) @(negedge clk);
      check("busy_cmd_ignored", {awvalid, arvalid, cmd_ready}, 3'b001);

      ar_delay = 20;
      xlog.delete();
      cmd_valid = 1'b1;
      cmd_a     = 32'd100;
      cmd_b     = 32'd200;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int i = 0; i < 60 && !(arvalid && araddr == 32'h0); i++) @(negedge clk);
      check("rdsum_arvalid", {arvalid, araddr}, {1'b1, 32'h0});
      rst = 1'b1;
      @(negedge clk);
      check("midrst_valids", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
      check("midrst_res_valid", res_valid, 1'b0);
      rst      = 1'b0;
      ar_delay = 0;
      @(negedge clk);
      check("midrst_cmd_ready", cmd_ready, 1'b1);
      check("midrst_no_res", res_valid, 1'b0);
      run_cmd(32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 16);
      take_resp();

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
